// File: rtl/fifo_stimulus_driver.sv
// Stimulus source for a FIFO under test: emits a pseudo-random push/pop/data stream
// that is legal by construction, tracks its own occupancy and checks it against full/empty.
module fifo_stimulus_driver #(
    parameter int          DEPTH     = 8,
    parameter int          WIDTH     = 8,
    parameter int          NUM_PKTS  = 32,
    parameter int          MAGIC_IDX = 5,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          CNTWID    = $clog2(DEPTH + 1),
    parameter int          PKTWID    = $clog2(NUM_PKTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              full,
    input  logic              empty,
    output logic              push,
    output logic              pop,
    output logic              start,
    output logic [WIDTH-1:0]  data_in,
    output logic [CNTWID-1:0] occ,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [PKTWID-1:0] sent_q, sent_d;
    logic [CNTWID-1:0] occ_q, occ_d;
    logic              err_q, err_d;
    logic              room, avail, flag_mismatch;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? 16'hB400 : 16'h0000);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            sent_q  <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sent_q  <= sent_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

    // Gating on both the DUT flags and our own count keeps strobes legal even on a mismatch.
    always_comb begin
        room          = ~full && (occ_q < CNTWID'(DEPTH));
        avail         = ~empty && (occ_q != '0);
        flag_mismatch = (full != (occ_q == CNTWID'(DEPTH))) || (empty != (occ_q == '0));
        push          = 1'b0;
        pop           = 1'b0;
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                push   = lfsr_q[0] && room && (sent_q < PKTWID'(NUM_PKTS));
                pop    = lfsr_q[1] && avail;
                lfsr_d = lfsr_next(lfsr_q);
                if (push && (sent_q == PKTWID'(NUM_PKTS - 1)))
                    state_d = DRAIN;
            end
            DRAIN: begin
                pop    = avail;
                lfsr_d = lfsr_next(lfsr_q);
                if ((occ_q == '0) && empty)
                    state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        start  = push && (sent_q == PKTWID'(MAGIC_IDX));
        sent_d = sent_q + PKTWID'(push);
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        err_d = err_q || ((state_q != IDLE) && flag_mismatch);
    end

    assign data_in = lfsr_q[WIDTH-1:0];
    assign occ     = occ_q;
    assign done    = (state_q == DONE);
    assign err     = err_q;

endmodule
